// File: rtl/seg8_scan_sched.sv
// Refresh scheduler for an 8-digit 7-segment display behind a 16-bit
// 74HC595 chain. Holds the digit framebuffer, scans the digits, decodes
// hex to segments, applies PWM brightness with interleaved blank words and
// hands one 16-bit shift word per event to the serializer (valid/ready).
module seg8_scan_sched #(
    parameter int DWELL_CYCLES = 12500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [3:0]  wr_nibble,
    input  logic        wr_dp,
    input  logic        wr_blank,
    input  logic        enable,
    input  logic [3:0]  brightness,
    output logic        word_valid,
    output logic [15:0] word_data,
    input  logic        word_ready,
    output logic        frame_done,
    output logic        busy
);

    // One brightness step; derived from the dwell so a slot always spans 16 steps.
    localparam int          SLICE_CYCLES = DWELL_CYCLES / 16;
    localparam logic [31:0] SLICE        = 32'(SLICE_CYCLES);
    localparam logic [15:0] BLANK_WORD   = 16'hFF00;

    typedef enum logic [2:0] {
        IDLE,
        SEND_ON,
        ON_HOLD,
        SEND_OFF,
        OFF_HOLD,
        NEXT
    } state_t;

    // Segment pattern {a,b,c,d,e,f,g,dp} for a hex value, dp cleared.
    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0: s = 8'hFC;
            4'h1: s = 8'h60;
            4'h2: s = 8'hDA;
            4'h3: s = 8'hF2;
            4'h4: s = 8'h66;
            4'h5: s = 8'hB6;
            4'h6: s = 8'hBE;
            4'h7: s = 8'hE0;
            4'h8: s = 8'hFE;
            4'h9: s = 8'hF6;
            4'hA: s = 8'hEE;
            4'hB: s = 8'h3E;
            4'hC: s = 8'h9C;
            4'hD: s = 8'h7A;
            4'hE: s = 8'h9E;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

    // Framebuffer entry layout: {blank, dp, nibble[3:0]}.
    logic [5:0] fb_reg [8];

    state_t      state_reg,    state_next;
    logic [2:0]  idx_reg,      idx_next;
    logic [31:0] timer_reg,    timer_next;
    logic        valid_reg,    valid_next;
    logic [15:0] data_reg,     data_next;
    logic        fd_reg,       fd_next;
    logic        shutdown_reg, shutdown_next;
    logic [3:0]  bright_reg,   bright_next;

    logic [7:0][15:0] digit_word;
    logic [31:0]      on_time;
    logic [31:0]      off_time;
    logic [2:0]       idx_inc;

    // Host writes land on the clock edge; reset leaves every digit blanked.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                fb_reg[i] <= 6'b10_0000;
            end
        end else if (wr_en) begin
            fb_reg[wr_addr] <= {wr_blank, wr_dp, wr_nibble};
        end
    end

    // Per-digit shift word: active-low one-hot digit select plus segments;
    // a blanked entry lights nothing and ignores its decimal point.
    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        localparam logic [7:0] DIG_N = ~(8'b1 << gi);
        assign digit_word[gi] = fb_reg[gi][5]
            ? {DIG_N, 8'h00}
            : {DIG_N, hex_seg(fb_reg[gi][3:0]) | {7'b0, fb_reg[gi][4]}};
    end

    assign on_time  = ({28'b0, bright_reg} + 32'd1) * SLICE;
    assign off_time = (32'd15 - {28'b0, bright_reg}) * SLICE;
    assign idx_inc  = idx_reg + 3'd1;

    // State and datapath registers; valid drops at once on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            idx_reg      <= 3'd0;
            timer_reg    <= 32'd0;
            valid_reg    <= 1'b0;
            data_reg     <= BLANK_WORD;
            fd_reg       <= 1'b0;
            shutdown_reg <= 1'b0;
            bright_reg   <= 4'd0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            timer_reg    <= timer_next;
            valid_reg    <= valid_next;
            data_reg     <= data_next;
            fd_reg       <= fd_next;
            shutdown_reg <= shutdown_next;
            bright_reg   <= bright_next;
        end
    end

    // Next-state logic: scan sequencing, handshakes, hold timers, shutdown.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        timer_next    = timer_reg;
        valid_next    = valid_reg;
        data_next     = data_reg;
        fd_next       = 1'b0;
        shutdown_next = shutdown_reg;
        bright_next   = bright_reg;

        case (state_reg)
            IDLE: begin
                if (enable) begin
                    state_next    = SEND_ON;
                    valid_next    = 1'b1;
                    data_next     = digit_word[idx_reg];
                    bright_next   = brightness;
                    shutdown_next = 1'b0;
                end
            end

            SEND_ON: begin
                // Hold timer starts only at the accept edge.
                if (word_ready) begin
                    valid_next = 1'b0;
                    state_next = ON_HOLD;
                    timer_next = on_time;
                end
            end

            ON_HOLD: begin
                if (!enable) begin
                    state_next    = SEND_OFF;
                    valid_next    = 1'b1;
                    data_next     = BLANK_WORD;
                    shutdown_next = 1'b1;
                end else if (timer_reg <= 32'd1) begin
                    if (bright_reg == 4'd15) begin
                        state_next = NEXT;
                    end else begin
                        state_next = SEND_OFF;
                        valid_next = 1'b1;
                        data_next  = BLANK_WORD;
                    end
                end else begin
                    timer_next = timer_reg - 32'd1;
                end
            end

            SEND_OFF: begin
                if (word_ready) begin
                    valid_next = 1'b0;
                    if (shutdown_reg || !enable) begin
                        state_next    = IDLE;
                        idx_next      = 3'd0;
                        shutdown_next = 1'b0;
                    end else begin
                        state_next = OFF_HOLD;
                        timer_next = off_time;
                    end
                end
            end

            OFF_HOLD: begin
                if (!enable) begin
                    state_next    = SEND_OFF;
                    valid_next    = 1'b1;
                    data_next     = BLANK_WORD;
                    shutdown_next = 1'b1;
                end else if (timer_reg <= 32'd1) begin
                    state_next = NEXT;
                end else begin
                    timer_next = timer_reg - 32'd1;
                end
            end

            NEXT: begin
                if (enable) begin
                    idx_next    = idx_inc;
                    fd_next     = (idx_reg == 3'd7);
                    state_next  = SEND_ON;
                    valid_next  = 1'b1;
                    data_next   = digit_word[idx_inc];
                    bright_next = brightness;
                end else begin
                    state_next    = SEND_OFF;
                    valid_next    = 1'b1;
                    data_next     = BLANK_WORD;
                    shutdown_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    assign word_valid = valid_reg;
    assign word_data  = data_reg;
    assign frame_done = fd_reg;
    assign busy       = (state_reg != IDLE);

endmodule
